l2_bank_port_arbiter: RTL



---
 rtl/l2_bank_port_arbiter_pkg.sv | 25 ++
 rtl/l2_bank_port_arbiter_if.sv | 46 ++++
 rtl/l2_bank_port_arbiter_rr_sel.sv | 47 ++++
 rtl/l2_bank_port_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/l2_bank_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : l2_bank_arb_pkg
// Brief   : Shared state encoding and width helpers for the L2 bank arbiter.
// Revision: 1.0
// ============================================================================
package l2_bank_arb_pkg;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } l2_bank_arb_state_e;

    // Clamped to 1 so a depth/port count of 1 still yields a legal vector.
    function automatic int unsigned addr_width(input int unsigned num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_bank_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : l2_bank_port_arbiter_if
// Brief   : Requester-side and bank-side signals of one L2 bank arbiter.
// Revision: 1.0
// ============================================================================
interface l2_bank_port_arbiter_if
    import l2_bank_arb_pkg::*;
#(
    parameter int NumPorts  = 2,
    parameter int AddrWidth = 10,
    parameter int DataWidth = 32
);
    localparam int BeWidth = int'(be_width(DataWidth));

    logic [NumPorts-1:0]                req_i;
    logic [NumPorts-1:0]                we_i;
    logic [NumPorts-1:0][AddrWidth-1:0] addr_i;
    logic [NumPorts-1:0][DataWidth-1:0] wdata_i;
    logic [NumPorts-1:0][BeWidth-1:0]   be_i;
    logic [NumPorts-1:0]                gnt_o;
    logic [NumPorts-1:0]                rvalid_o;
    logic [DataWidth-1:0]               rdata_o;

    logic                               bank_req_o;
    logic                               bank_we_o;
    logic [AddrWidth-1:0]               bank_addr_o;
    logic [DataWidth-1:0]               bank_wdata_o;
    logic [BeWidth-1:0]                 bank_be_o;
    logic [DataWidth-1:0]               bank_rdata_i;

    // The arbiter is the slave of the requesters and drives the bank.
    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, bank_rdata_i,
        output gnt_o, rvalid_o, rdata_o,
               bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, bank_rdata_i,
        input  gnt_o, rvalid_o, rdata_o,
               bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, bank_be_o
    );

endinterface
`default_nettype wire

// File: rtl/l2_bank_port_arbiter_rr_sel.sv
`default_nettype none
// ============================================================================
// Module  : l2_bank_rr_sel
// Brief   : Combinational rotate-priority selector: first request at/after ptr.
// Revision: 1.0
// ============================================================================
module l2_bank_rr_sel
    import l2_bank_arb_pkg::*;
#(
    parameter int NumPorts = 2,
    parameter int IdxWidth = 1
) (
    input  logic [NumPorts-1:0] i_req,
    input  logic [IdxWidth-1:0] i_rr_ptr,
    output logic [NumPorts-1:0] o_gnt,
    output logic [IdxWidth-1:0] o_idx,
    output logic                o_valid
);

    localparam int CandWidth = IdxWidth + 1;

    logic [CandWidth-1:0] w_cand;
    logic [IdxWidth-1:0]  w_cand_idx;

    // One extra bit holds ptr+offset before the modulo-NumPorts fold.
    always_comb begin
        o_gnt      = '0;
        o_idx      = '0;
        o_valid    = 1'b0;
        w_cand     = '0;
        w_cand_idx = '0;
        for (int i = 0; i < NumPorts; i++) begin
            w_cand = {1'b0, i_rr_ptr} + CandWidth'(i);
            if (w_cand >= CandWidth'(NumPorts)) begin
                w_cand = w_cand - CandWidth'(NumPorts);
            end
            w_cand_idx = w_cand[IdxWidth-1:0];
            if (!o_valid && i_req[w_cand_idx]) begin
                o_valid           = 1'b1;
                o_idx             = w_cand_idx;
                o_gnt[w_cand_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_bank_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : l2_bank_port_arbiter
// Brief   : Zero-fills one L2 SRAM bank after reset, then round-robin shares it.
// Revision: 1.0
// ============================================================================
module l2_bank_port_arbiter
    import l2_bank_arb_pkg::*;
#(
    parameter int NumPorts    = 2,
    parameter int NumWords    = 1024,
    parameter int DataWidth   = 32,
    parameter int InitOnReset = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    l2_bank_port_arbiter_if.slave arb_if,
    output logic                  init_done_o
);

    localparam int AddrWidth = int'(addr_width(NumWords));
    localparam int BeWidth   = int'(be_width(DataWidth));
    localparam int IdxWidth  = int'(addr_width(NumPorts));

    localparam logic [AddrWidth-1:0] c_LAST_ADDR = AddrWidth'(NumWords - 1);
    localparam logic [IdxWidth-1:0]  c_LAST_IDX  = IdxWidth'(NumPorts - 1);

    l2_bank_arb_state_e   r_state;
    l2_bank_arb_state_e   w_state_next;
    logic [AddrWidth-1:0] r_cnt;
    logic [IdxWidth-1:0]  r_rr;
    logic [NumPorts-1:0]  r_rvalid;

    logic [NumPorts-1:0]  w_sel_gnt;
    logic [IdxWidth-1:0]  w_sel_idx;
    logic                 w_sel_valid;
    logic                 w_run;

    l2_bank_rr_sel #(
        .NumPorts (NumPorts),
        .IdxWidth (IdxWidth)
    ) u_rr_sel (
        .i_req    (arb_if.req_i),
        .i_rr_ptr (r_rr),
        .o_gnt    (w_sel_gnt),
        .o_idx    (w_sel_idx),
        .o_valid  (w_sel_valid)
    );

    assign w_run = (r_state == RUN);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            WAIT:    w_state_next = (InitOnReset != 0) ? INIT : RUN;
            INIT:    if (r_cnt == c_LAST_ADDR) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = WAIT;
        endcase
    end

    always_comb begin
        arb_if.gnt_o        = '0;
        arb_if.bank_req_o   = 1'b0;
        arb_if.bank_we_o    = 1'b0;
        arb_if.bank_addr_o  = '0;
        arb_if.bank_wdata_o = '0;
        arb_if.bank_be_o    = '0;
        unique case (r_state)
            INIT: begin
                arb_if.bank_req_o  = 1'b1;
                arb_if.bank_we_o   = 1'b1;
                arb_if.bank_addr_o = r_cnt;
                arb_if.bank_be_o   = '1;
            end
            RUN: begin
                if (w_sel_valid) begin
                    arb_if.gnt_o        = w_sel_gnt;
                    arb_if.bank_req_o   = 1'b1;
                    arb_if.bank_we_o    = arb_if.we_i[w_sel_idx];
                    arb_if.bank_addr_o  = arb_if.addr_i[w_sel_idx];
                    arb_if.bank_wdata_o = arb_if.wdata_i[w_sel_idx];
                    arb_if.bank_be_o    = arb_if.be_i[w_sel_idx];
                end
            end
            default: ;
        endcase
    end

    // The counter returns to 0 on the last INIT write so a later pass starts clean.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == INIT) begin
            r_cnt <= (r_cnt == c_LAST_ADDR) ? '0 : r_cnt + AddrWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr     <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_run ? w_sel_gnt : '0;
            if (w_run && w_sel_valid) begin
                r_rr <= (w_sel_idx == c_LAST_IDX) ? '0 : w_sel_idx + IdxWidth'(1);
            end
        end
    end

    assign arb_if.rvalid_o = r_rvalid;
    assign arb_if.rdata_o  = arb_if.bank_rdata_i;
    assign init_done_o     = w_run;

endmodule
`default_nettype wire
